// File: rtl/mdu_pkg.sv
// mdu_pkg: opcodes, FSM states and opcode-class helpers
// shared by the iterative multiply/divide unit.
package mdu_pkg;

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MADD  = 4'd5;
   localparam logic [3:0] OP_MADDU = 4'd6;
   localparam logic [3:0] OP_MSUB  = 4'd7;
   localparam logic [3:0] OP_MSUBU = 4'd8;
   localparam logic [3:0] OP_MTHI  = 4'd9;
   localparam logic [3:0] OP_MTLO  = 4'd10;
   localparam logic [3:0] OP_MFHI  = 4'd11;
   localparam logic [3:0] OP_MFLO  = 4'd12;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIX
   } state_t;

   function automatic logic is_arith(input logic [3:0] op);
      return (op >= OP_MULT) && (op <= OP_MSUBU);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_signed(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_DIV) ||
             (op == OP_MADD) || (op == OP_MSUB);
   endfunction

   function automatic logic is_acc(input logic [3:0] op);
      return (op == OP_MADD) || (op == OP_MADDU);
   endfunction

   function automatic logic is_sub(input logic [3:0] op);
      return (op == OP_MSUB) || (op == OP_MSUBU);
   endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the EX stage
// and the multiply/divide unit.
interface mdu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             abort;
   logic [WIDTH-1:0] rd_data;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;
   logic             busy;
   logic             done;

   modport master (
      output start, op, a, b, abort,
      input  rd_data, hi_o, lo_o, busy, done
   );

   modport slave (
      input  start, op, a, b, abort,
      output rd_data, hi_o, lo_o, busy, done
   );
endinterface

// File: rtl/mdu_div_step.sv
// mdu_div_step: BITS_PER_CYCLE restoring-divide steps,
// quotient bits shift in at the bottom of quo.
module mdu_div_step #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dvs,
   output logic [WIDTH-1:0] rem_nxt,
   output logic [WIDTH-1:0] quo_nxt
);

   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;

   // shift one dividend bit into the partial remainder, subtract if it fits
   always_comb begin
      r     = rem;
      q     = quo;
      trial = '0;
      for (int k = 0; k < BITS_PER_CYCLE; k++) begin
         trial = {r, q[WIDTH-1]};
         q     = {q[WIDTH-2:0], 1'b0};
         if (trial >= {1'b0, dvs}) begin
            trial = trial - {1'b0, dvs};
            q[0]  = 1'b1;
         end
         r = trial[WIDTH-1:0];
      end
      rem_nxt = r;
      quo_nxt = q;
   end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative shift-add multiply / restoring divide
// with HI/LO, accumulate and pipeline abort.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic  clk,
   input logic  reset,
   mdu_if.slave bus
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = $clog2(N);
   localparam int W2 = 2 * WIDTH;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, hi, lo;
   logic [WIDTH-1:0] rem, quo, dvs, mpl;
   logic [WIDTH-1:0] rem_nxt, quo_nxt;
   logic [W2-1:0]    mcd, acc, acc_nxt, hilo_q;
   logic             neg_q, rneg_q, dz_q, done_q;
   logic             sgn, a_neg, b_neg;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic [WIDTH-1:0] q_fix, r_fix;
   logic [W2-1:0]    p_fix, res;
   logic             accept;

   assign accept = bus.start && !bus.abort;
   assign sgn    = is_signed(op_q);
   assign a_neg  = sgn & a_q[WIDTH-1];
   assign b_neg  = sgn & b_q[WIDTH-1];
   assign a_abs  = a_neg ? -a_q : a_q;
   assign b_abs  = b_neg ? -b_q : b_q;

   mdu_div_step #(
      .WIDTH          (WIDTH),
      .BITS_PER_CYCLE (BITS_PER_CYCLE)
   ) u_div (
      .rem     (rem),
      .quo     (quo),
      .dvs     (dvs),
      .rem_nxt (rem_nxt),
      .quo_nxt (quo_nxt)
   );

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next state; abort while busy overrides every transition
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (accept && is_arith(bus.op)) state_nxt = S_PREP;
         S_PREP: state_nxt = S_ITER;
         S_ITER: if (cnt == CW'(N - 1)) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (state != S_IDLE && bus.abort) state_nxt = S_IDLE;
   end

   // shift-add multiply step over the low multiplier bits
   always_comb begin
      acc_nxt = acc;
      for (int k = 0; k < BITS_PER_CYCLE; k++)
         if (mpl[k]) acc_nxt = acc_nxt + (mcd << k);
   end

   // sign correction and accumulate for the FIX write
   always_comb begin
      q_fix = neg_q  ? -quo : quo;
      r_fix = rneg_q ? -rem : rem;
      p_fix = neg_q  ? -acc : acc;
      res   = p_fix;
      unique case (1'b1)
         is_div(op_q): res = {r_fix, q_fix};
         is_sub(op_q): res = hilo_q - p_fix;
         is_acc(op_q): res = hilo_q + p_fix;
         default: ;
      endcase
   end

   // operand capture, iteration datapath and HI/LO update
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         op_q   <= OP_NOP;
         a_q    <= '0;
         b_q    <= '0;
         hi     <= '0;
         lo     <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         mpl    <= '0;
         mcd    <= '0;
         acc    <= '0;
         hilo_q <= '0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         dz_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (accept && is_arith(bus.op)) begin
                  op_q <= bus.op;
                  a_q  <= bus.a;
                  b_q  <= bus.b;
               end else if (accept && bus.op == OP_MTHI) begin
                  hi <= bus.a;
               end else if (accept && bus.op == OP_MTLO) begin
                  lo <= bus.a;
               end
            end
            S_PREP: begin
               mcd    <= {{WIDTH{1'b0}}, a_abs};
               mpl    <= b_abs;
               acc    <= '0;
               rem    <= '0;
               quo    <= a_abs;
               dvs    <= b_abs;
               neg_q  <= a_neg ^ b_neg;
               rneg_q <= a_neg;
               dz_q   <= is_div(op_q) && (b_q == '0);
               hilo_q <= {hi, lo};
               cnt    <= '0;
            end
            S_ITER: begin
               cnt <= cnt + CW'(1);
               if (is_div(op_q)) begin
                  rem <= rem_nxt;
                  quo <= quo_nxt;
               end else begin
                  acc <= acc_nxt;
                  mcd <= mcd << BITS_PER_CYCLE;
                  mpl <= mpl >> BITS_PER_CYCLE;
               end
            end
            S_FIX: begin
               if (!bus.abort) begin
                  done_q <= 1'b1;
                  if (!dz_q) {hi, lo} <= res;
               end
            end
            default: ;
         endcase
      end
   end

   // MFHI/MFLO read port, combinational on the current op
   always_comb begin
      bus.rd_data = '0;
      if (bus.op == OP_MFHI)      bus.rd_data = hi;
      else if (bus.op == OP_MFLO) bus.rd_data = lo;
   end

   assign bus.hi_o = hi;
   assign bus.lo_o = lo;
   assign bus.busy = (state != S_IDLE);
   assign bus.done = done_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed + random checks of mdu_iter
// against a plain-arithmetic HI/LO model.
module tb_mdu_iter;
   import mdu_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   compared = 0;
   int   mismatched = 0;
   logic [31:0] mhi = '0;
   logic [31:0] mlo = '0;

   mdu_if #(.WIDTH(32)) bus ();

   mdu_iter #(
      .WIDTH          (32),
      .BITS_PER_CYCLE (1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_op(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
      longint      sp;
      logic [63:0] up, hl;
      sp = longint'($signed(a)) * longint'($signed(b));
      up = {32'd0, a} * {32'd0, b};
      hl = {mhi, mlo};
      case (op)
         OP_MULT:  hl = sp;
         OP_MULTU: hl = up;
         OP_MADD:  hl = hl + sp;
         OP_MADDU: hl = hl + up;
         OP_MSUB:  hl = hl - sp;
         OP_MSUBU: hl = hl - up;
         OP_DIV:
            if (b != 0) begin
               if (a == 32'h80000000 && b == 32'hFFFFFFFF)
                  hl = {32'd0, a};
               else
                  hl = {32'($signed(a) % $signed(b)),
                        32'($signed(a) / $signed(b))};
            end
         OP_DIVU:
            if (b != 0) hl = {a % b, a / b};
         default: ;
      endcase
      {mhi, mlo} = hl;
   endtask

   task automatic chk_hilo(input string tag);
      chk({tag, "_hi"}, 64'(bus.hi_o), 64'(mhi));
      chk({tag, "_lo"}, 64'(bus.lo_o), 64'(mlo));
   endtask

   // abort_at: busy cycle (1-based) during which abort is raised, 0 = none
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int abort_at);
      int n;
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      bus.abort = 1'b0;
      tick();
      n = 0;
      while (bus.busy && n < 100) begin
         n++;
         bus.start = 1'($urandom_range(0, 1));
         bus.op    = 4'($urandom_range(0, 12));
         bus.a     = $urandom;
         bus.b     = $urandom;
         bus.abort = (n == abort_at);
         tick();
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.op    = OP_NOP;
      if (abort_at == 0) begin
         model_op(op, a, b);
         chk({tag, "_busylen"}, 64'(n), 64'd34);
         chk({tag, "_done"}, 64'(bus.done), 64'd1);
      end else begin
         chk({tag, "_abortlen"}, 64'(n), 64'(abort_at));
         chk({tag, "_nodone"}, 64'(bus.done), 64'd0);
      end
      chk_hilo(tag);
      tick();
      chk({tag, "_doneclr"}, 64'(bus.done), 64'd0);
   endtask

   task automatic mt(input string tag, input logic [3:0] op,
                     input logic [31:0] v);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = v;
      tick();
      bus.start = 1'b0;
      bus.op    = OP_NOP;
      if (op == OP_MTHI) mhi = v;
      else               mlo = v;
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_done"}, 64'(bus.done), 64'd0);
      chk_hilo(tag);
   endtask

   initial begin
      logic [3:0]  rop;
      logic [31:0] ra, rb;
      bus.start = 1'b0;
      bus.op    = OP_NOP;
      bus.a     = '0;
      bus.b     = '0;
      bus.abort = 1'b0;
      #12;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk_hilo("rst");
      reset = 1'b0;
      tick();

      run_op("mult", OP_MULT, 32'hFFFFFFFF, 32'h2, 0);
      chk("mult_lit", {bus.hi_o, bus.lo_o}, 64'hFFFFFFFF_FFFFFFFE);
      run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'h2, 0);
      chk("multu_lit", {bus.hi_o, bus.lo_o}, 64'h00000001_FFFFFFFE);
      run_op("div", OP_DIV, 32'hFFFFFFF9, 32'h2, 0);
      chk("div_lit", {bus.hi_o, bus.lo_o}, 64'hFFFFFFFF_FFFFFFFD);
      run_op("divmin", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
      chk("divmin_lit", {bus.hi_o, bus.lo_o}, 64'h00000000_80000000);

      mt("mthi0", OP_MTHI, 32'h0);
      mt("mtlo", OP_MTLO, 32'hFFFFFFFF);
      run_op("maddu", OP_MADDU, 32'h1, 32'h1, 0);
      chk("maddu_lit", {bus.hi_o, bus.lo_o}, 64'h00000001_00000000);
      run_op("msub", OP_MSUB, 32'h1, 32'h1, 0);
      chk("msub_lit", {bus.hi_o, bus.lo_o}, 64'h00000000_FFFFFFFF);

      mt("mthi11", OP_MTHI, 32'h11);
      mt("mtlo22", OP_MTLO, 32'h22);
      run_op("divz", OP_DIVU, 32'h7, 32'h0, 0);
      chk("divz_lit", {bus.hi_o, bus.lo_o}, 64'h00000011_00000022);

      bus.op = OP_MFHI;
      #1 chk("rd_mfhi", 64'(bus.rd_data), 64'(mhi));
      bus.op = OP_MFLO;
      #1 chk("rd_mflo", 64'(bus.rd_data), 64'(mlo));
      bus.op = OP_NOP;
      #1 chk("rd_nop", 64'(bus.rd_data), 64'd0);

      run_op("abort10", OP_MULT, 32'h1234, 32'h5678, 10);
      run_op("abortfix", OP_DIVU, 32'h1000, 32'h3, 34);

      bus.start = 1'b1;
      bus.op    = OP_MULT;
      bus.a     = 32'h9;
      bus.b     = 32'h9;
      bus.abort = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      chk("idle_abort_busy", 64'(bus.busy), 64'd0);
      tick();
      chk("idle_abort_done", 64'(bus.done), 64'd0);
      chk_hilo("idle_abort");

      for (int i = 0; i < 24; i++) begin
         rop = 4'($urandom_range(1, 8));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 7) == 0) rb = 32'h0;
         if ($urandom_range(0, 7) == 0) begin
            ra = 32'h80000000;
            rb = 32'hFFFFFFFF;
         end
         if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
         if ($urandom_range(0, 5) == 0)
            mt("rnd_mt", ($urandom_range(0, 1) == 1) ? OP_MTHI : OP_MTLO,
               $urandom);
         run_op("rnd", rop, ra, rb, 0);
      end

      bus.start = 1'b1;
      bus.op    = OP_MULT;
      bus.a     = 32'hDEAD;
      bus.b     = 32'hBEEF;
      tick();
      bus.start = 1'b0;
      repeat (5) tick();
      #2 reset = 1'b1;
      #1;
      mhi = '0;
      mlo = '0;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_done", 64'(bus.done), 64'd0);
      chk_hilo("arst");
      #13 reset = 1'b0;
      tick();
      run_op("mul35", OP_MULT, 32'd3, 32'd5, 0);
      chk("mul35_lit", {bus.hi_o, bus.lo_o}, 64'd15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
